// File: rtl/llc_cmd_dispatch.sv
// Trace command dispatcher for the LLC model: legal-opcode filter, decode FIFO,
// valid/ready issue and global-clear serialisation. Optional LLC_STATS_EN adds rd/wr counters.
`timescale 1ns/1ps
module llc_cmd_dispatch #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned INDEX_W  = 15,
  parameter int unsigned TAG_W    = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_cmd,
  input  logic [31:0]               in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                out_cmd,
  output logic [TAG_W-1:0]          out_tag,
  output logic [INDEX_W-1:0]        out_index,
  output logic [OFFSET_W-1:0]       out_offset,
  output logic [1:0]                out_class,
  input  logic                      clr_done,
  output logic [7:0]                err_cnt,
  output logic [$clog2(DEPTH):0]    fifo_cnt
`ifdef LLC_STATS_EN
  ,
  output logic [31:0]               rd_cnt,
  output logic [31:0]               wr_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [3:0]          cmd;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [1:0]          cls;
  } entry_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_CLR = 1'b1
  } state_e;

  state_e             state_q, state_d;
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         err_q, err_d;

  entry_t             wr_entry;
  entry_t             head;
  logic               cmd_legal;
  logic               accept;
  logic               push;
  logic               pop;

  // Decode at enqueue so the head drives the core straight from storage
  always_comb begin
    cmd_legal = (in_cmd <= 4'd6) || (in_cmd == 4'd8) || (in_cmd == 4'd9);
    wr_entry.cmd    = in_cmd;
    wr_entry.tag    = in_addr[OFFSET_W+INDEX_W +: TAG_W];
    wr_entry.index  = in_addr[OFFSET_W +: INDEX_W];
    wr_entry.offset = in_addr[OFFSET_W-1:0];
    if (in_cmd <= 4'd2) begin
      wr_entry.cls = 2'd0;
    end else if (in_cmd <= 4'd6) begin
      wr_entry.cls = 2'd1;
    end else begin
      wr_entry.cls = 2'd2;
    end
  end

  assign in_ready = (cnt_q < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && cmd_legal;
  assign pop      = out_valid && out_ready;
  assign head     = mem_q[rd_ptr_q];
  assign fifo_cnt = cnt_q;
  assign err_cnt  = err_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and issue outputs; payload forced to zero when nothing is offered
  always_comb begin
    state_d    = state_q;
    out_valid  = 1'b0;
    out_cmd    = '0;
    out_tag    = '0;
    out_index  = '0;
    out_offset = '0;
    out_class  = '0;
    case (state_q)
      ST_RUN: begin
        out_valid = (cnt_q != '0);
        if (out_valid) begin
          out_cmd    = head.cmd;
          out_tag    = head.tag;
          out_index  = head.index;
          out_offset = head.offset;
          out_class  = head.cls;
          if (out_ready && (head.cmd == 4'd8)) begin
            state_d = ST_WAIT_CLR;
          end
        end
      end
      ST_WAIT_CLR: begin
        if (clr_done) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pointer, occupancy and error-counter next state
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q;
    if (accept && !cmd_legal && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage array needs no reset: unread entries are never offered
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

`ifdef LLC_STATS_EN
  logic [31:0] rd_q, rd_d;
  logic [31:0] wr_q, wr_d;

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (pop) begin
      if ((head.cmd == 4'd0) || (head.cmd == 4'd2)) begin
        rd_d = rd_q + 32'd1;
      end
      if (head.cmd == 4'd1) begin
        wr_d = wr_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  assign rd_cnt = rd_q;
  assign wr_cnt = wr_q;
`endif

endmodule

// File: tb/tb_llc_cmd_dispatch.sv
// Scoreboard bench for llc_cmd_dispatch: expected decodes queued at enqueue, compared at issue.
`timescale 1ns/1ps
module tb_llc_cmd_dispatch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_cmd;
  logic [10:0] out_tag;
  logic [14:0] out_index;
  logic [5:0]  out_offset;
  logic [1:0]  out_class;
  logic        clr_done;
  logic [7:0]  err_cnt;
  logic [2:0]  fifo_cnt;
`ifdef LLC_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  typedef struct packed {
    logic [3:0]  cmd;
    logic [10:0] tag;
    logic [14:0] idx;
    logic [5:0]  off;
    logic [1:0]  cls;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_issued = 0;

  llc_cmd_dispatch #(.DEPTH(4), .OFFSET_W(6), .INDEX_W(15), .TAG_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .out_class(out_class), .clr_done(clr_done), .err_cnt(err_cnt), .fifo_cnt(fifo_cnt)
`ifdef LLC_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] c);
    case (c)
      4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a);
    exp_t e;
    e.cmd = c;
    e.tag = a[31:21];
    e.idx = a[20:6];
    e.off = a[5:0];
    case (c)
      4'd0, 4'd1, 4'd2:       e.cls = 2'd0;
      4'd3, 4'd4, 4'd5, 4'd6: e.cls = 2'd1;
      default:                e.cls = 2'd2;
    endcase
    return e;
  endfunction

  // Present one command for one cycle; returns whether it was accepted
  task automatic send(input logic [3:0] c, input logic [31:0] a, output bit acc);
    in_valid = 1'b1;
    in_cmd   = c;
    in_addr  = a;
    @(negedge clk);
    acc = in_ready;
    if (acc && is_legal(c)) exp_q.push_back(model(c, a));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_done = 1'b1;
    @(posedge clk);
    #1 clr_done = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 50;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Compare every issued command against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_issued++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_issue", 64'(out_cmd), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_cmd", 64'(out_cmd), 64'(e.cmd));
        check("sb_tag", 64'(out_tag), 64'(e.tag));
        check("sb_index", 64'(out_index), 64'(e.idx));
        check("sb_offset", 64'(out_offset), 64'(e.off));
        check("sb_class", 64'(out_class), 64'(e.cls));
      end
    end
  end

  initial begin
    bit acc;
    int n0;
    logic [3:0] ill;
    rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_addr = '0;
    out_ready = 1'b0; clr_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_cmd", 64'(out_cmd), 64'd0);
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single command latency and field split
    out_ready = 1'b1;
    send(4'd0, 32'h1234_5678, acc);
    check("single_acc", 64'(acc), 64'd1);
    @(negedge clk);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_tag", 64'(out_tag), 64'h091);
    check("single_index", 64'(out_index), 64'h5159);
    check("single_offset", 64'(out_offset), 64'h38);
    check("single_class", 64'(out_class), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("single_empty", 64'(out_valid), 64'd0);
`ifdef LLC_STATS_EN
    check("single_rd_cnt", 64'(rd_cnt), 64'd1);
`endif
    @(posedge clk); #1;

    // Fill to DEPTH with core stalled, then drain in order
    out_ready = 1'b0;
    send(4'd1, 32'hA000_0001, acc);
    send(4'd2, 32'h5555_AAAA, acc);
    send(4'd5, 32'hFFFF_FFFF, acc);
    send(4'd9, 32'h0000_0040, acc);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_fifo_cnt", 64'(fifo_cnt), 64'd4);
    check("full_hold_cmd", 64'(out_cmd), 64'd1);
    send(4'd3, 32'h1111_1111, acc);
    check("full_5th_rejected", 64'(acc), 64'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // Opcode 8 blocks issue until clr_done
    send(4'd8, 32'hDEAD_BEEF, acc);
    send(4'd0, 32'h0000_1234, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("clr_wait_valid", 64'(out_valid), 64'd0);
    end
    pulse_clr();
    @(negedge clk);
    check("clr_release_valid", 64'(out_valid), 64'd1);
    check("clr_release_cmd", 64'(out_cmd), 64'd0);
    @(posedge clk); #1;

    // clr_done coincident with the opcode-8 handshake is ignored
    send(4'd8, 32'h0000_0000, acc);
    clr_done = 1'b1;
    @(posedge clk);
    #1 clr_done = 1'b0;
    send(4'd2, 32'h8000_0000, acc);
    repeat (3) begin
      @(negedge clk);
      check("clr_same_cycle_valid", 64'(out_valid), 64'd0);
    end
    check("clr_same_cycle_cnt", 64'(fifo_cnt), 64'd1);
    pulse_clr();
    drain("clr_same_cycle_drain");

    // clr_done while running has no effect
    pulse_clr();
    send(4'd4, 32'h0246_8ACE, acc);
    @(negedge clk);
    check("clr_in_run_valid", 64'(out_valid), 64'd1);
    drain("clr_in_run_drain");

    // Illegal opcodes: accepted, counted, never issued
    n0 = n_issued;
    send(4'd7, 32'h0, acc);
    check("ill7_acc", 64'(acc), 64'd1);
    send(4'd15, 32'h0, acc);
    check("ill15_acc", 64'(acc), 64'd1);
    @(negedge clk);
    check("ill_err_cnt", 64'(err_cnt), 64'd2);
    check("ill_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("ill_not_issued", 64'(n_issued), 64'(n0));
    @(posedge clk); #1;
    for (int i = 0; i < 300; i++) begin
      ill = (i % 2 == 0) ? 4'd7 : 4'(10 + $urandom_range(0, 5));
      send(ill, $urandom, acc);
    end
    @(negedge clk);
    check("ill_err_sat", 64'(err_cnt), 64'd255);
    @(posedge clk); #1;

    // Steady push/pop at occupancy 2 across pointer wrap
    out_ready = 1'b0;
    send(4'd3, 32'h1000_0000, acc);
    send(4'd6, 32'h2000_0000, acc);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(4'(i % 7), $urandom, acc);
      check("steady_fifo_cnt", 64'(fifo_cnt), 64'd2);
    end
    drain("steady_drain");

    // Asynchronous reset while waiting for clear with 3 queued
    send(4'd8, 32'h0, acc);
    send(4'd1, 32'h1, acc);
    send(4'd2, 32'h2, acc);
    send(4'd3, 32'h3, acc);
    check("wclr_fifo_cnt", 64'(fifo_cnt), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_payload", 64'({out_cmd, out_tag, out_index, out_offset, out_class}), 64'd0);
    check("arst_err_cnt", 64'(err_cnt), 64'd0);
    check("arst_fifo_cnt", 64'(fifo_cnt), 64'd0);
`ifdef LLC_STATS_EN
    check("arst_rd_cnt", 64'(rd_cnt), 64'd0);
    check("arst_wr_cnt", 64'(wr_cnt), 64'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(4'd1, 32'hCAFE_F00D, acc);
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_cmd", 64'(out_cmd), 64'd1);
    @(posedge clk);
    @(negedge clk);
`ifdef LLC_STATS_EN
    check("post_rst_wr_cnt", 64'(wr_cnt), 64'd1);
`endif
    check("post_rst_empty", 64'(out_valid), 64'd0);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
